// File: rtl/act_lut_interp_pkg.sv
// Shared widths and record types for the activation LUT interpolation stage.
// Pure declarations plus the signed LUT-delta helper; no state.
package act_lut_interp_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int FRAC_W = DATA_W - ADDR_W;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [DATA_W:0]   diff_t;
  typedef logic [ADDR_W-1:0]        addr_t;
  typedef logic [FRAC_W-1:0]        frac_t;

  typedef struct packed {
    addr_t addr;
    frac_t frac;
    logic  valid;
  } stage_a_t;

  typedef struct packed {
    sample_t base;
    diff_t   diff;
    frac_t   frac;
    logic    valid;
  } stage_b_t;

  // One extra bit so next - base never wraps for any pair of samples.
  function automatic diff_t lut_delta(input sample_t base, input sample_t nxt);
    return diff_t'(nxt) - diff_t'(base);
  endfunction

endpackage

// File: rtl/act_interp_datapath.sv
// Combinational interpolation y = base + floor(diff * frac / 2^FRAC_W), no latency.
// No flow control; the result always lies between base and base + diff.
module act_interp_datapath
  import act_lut_interp_pkg::*;
(
  input  logic [DATA_W-1:0] base,
  input  logic [DATA_W:0]   diff,
  input  logic [FRAC_W-1:0] frac,
  output logic [DATA_W-1:0] y
);

  localparam int PROD_W = DATA_W + FRAC_W + 2;

  logic signed [FRAC_W:0]   frac_s;
  logic signed [PROD_W-1:0] prod;

  assign frac_s = signed'({1'b0, frac});
  assign prod   = PROD_W'(signed'(diff)) * PROD_W'(frac_s);

  // Arithmetic shift floors toward minus infinity, keeping y inside [base, next].
  assign y = DATA_W'(PROD_W'(signed'(base)) + (prod >>> FRAC_W));

endmodule

// File: rtl/act_lut_interp.sv
// Piecewise-linear activation: split sample into LUT addr/frac, capture LUT pair, interpolate.
// Latency 3 cycles at 1 sample/cycle; the whole pipe freezes while out_valid && !out_ready.
module act_lut_interp
  import act_lut_interp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [ADDR_W-1:0] lut_address,
  input  logic [DATA_W-1:0] lut_base,
  input  logic [DATA_W-1:0] lut_next,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  stage_a_t          a_q;
  stage_b_t          b_q;
  logic              en;
  logic [DATA_W-1:0] y;

  assign en          = !out_valid || out_ready;
  assign in_ready    = en;
  assign lut_address = a_q.addr;

  act_interp_datapath u_datapath (
    .base (b_q.base),
    .diff (b_q.diff),
    .frac (b_q.frac),
    .y    (y)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q       <= '0;
      b_q       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      a_q <= '{addr:  in_data[DATA_W-1 -: ADDR_W],
               frac:  in_data[FRAC_W-1:0],
               valid: in_valid && in_ready};
      // LUT answers combinationally for the address held in stage A.
      b_q <= '{base:  sample_t'(lut_base),
               diff:  lut_delta(sample_t'(lut_base), sample_t'(lut_next)),
               frac:  a_q.frac,
               valid: a_q.valid};
      out_data  <= y;
      out_valid <= b_q.valid;
    end
  end

  diff_t base_ext;
  diff_t next_ext;
  diff_t y_ext;
  logic  y_in_range;

  assign base_ext   = diff_t'(b_q.base);
  assign next_ext   = base_ext + b_q.diff;
  assign y_ext      = diff_t'(sample_t'(y));
  assign y_in_range = (b_q.diff >= 0) ? (y_ext >= base_ext && y_ext <= next_ext)
                                      : (y_ext <= base_ext && y_ext >= next_ext);

  a_interp_range: assert property (@(posedge clk) disable iff (!rst) b_q.valid |-> y_in_range);

endmodule

// File: tb/tb_act_lut_interp.sv
// Bench for act_lut_interp: directed scenarios plus randomized traffic against a
// behavioural model of the LUT interpolation, scored at the output handshake.
module tb_act_lut_interp;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic [3:0] lut_address;
  logic [7:0] lut_base;
  logic [7:0] lut_next;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;

  logic signed [7:0] lut [16];
  logic [3:0]        nxt_addr;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_q[$];
  int lo_q[$];
  int hi_q[$];

  always #5 clk = ~clk;

  act_lut_interp dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .lut_address (lut_address),
    .lut_base    (lut_base),
    .lut_next    (lut_next),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data)
  );

  // Bench LUT: next clamps at the top positive entry, wraps from entry 15 to entry 0.
  assign nxt_addr = (lut_address == 4'd7) ? 4'd7 : lut_address + 4'd1;
  assign lut_base = lut[lut_address];
  assign lut_next = lut[nxt_addr];

  function automatic void model(input logic [7:0] x, output int y, output int lo, output int hi);
    int a, f, na, b, n, p, q;
    a  = int'(x[7:4]);
    f  = int'(x[3:0]);
    na = (a == 7) ? 7 : (a + 1) % 16;
    b  = int'(lut[a]);
    n  = int'(lut[na]);
    p  = (n - b) * f;
    q  = (p >= 0) ? p / 16 : -((-p + 15) / 16);
    y  = b + q;
    lo = (b < n) ? b : n;
    hi = (b < n) ? n : b;
  endfunction

  task automatic set_identity_lut();
    for (int i = 0; i < 16; i++) lut[i] = (i < 8) ? 8'(16 * i) : 8'sd0;
  endtask

  // Scoreboard on the handshakes that the coming rising edge will perform.
  always @(negedge clk) begin
    int e, l, h, my, ml, mh;
    if (rst !== 1'b1) begin
      exp_q.delete();
      lo_q.delete();
      hi_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_extra: got out_data=%0d, expected no output", $signed(out_data));
        end else begin
          e = exp_q.pop_front();
          l = lo_q.pop_front();
          h = hi_q.pop_front();
          if (int'($signed(out_data)) !== e) begin
            n_fail++;
            $display("FAIL sb_data: got %0d, expected %0d", $signed(out_data), e);
          end
          n_cmp++;
          if (int'($signed(out_data)) < l || int'($signed(out_data)) > h) begin
            n_fail++;
            $display("FAIL sb_range: got %0d, expected within [%0d,%0d]", $signed(out_data), l, h);
          end
        end
      end
      if (in_valid && in_ready) begin
        model(in_data, my, ml, mh);
        exp_q.push_back(my);
        lo_q.push_back(ml);
        hi_q.push_back(mh);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pushes one sample into an idle pipe and records out_valid over the next three cycles.
  task automatic run_single(input logic [7:0] x, output logic [2:0] vh, output logic [7:0] y);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = x;
    tick();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    vh[0] = out_valid;
    tick();
    vh[1] = out_valid;
    tick();
    vh[2] = out_valid;
    y     = out_data;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h, expected 00", out_data); end
    n_cmp++; if (lut_address !== 4'h0) begin n_fail++; $display("FAIL reset_lut_address: got %h, expected 0", lut_address); end
    rst = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b, expected 1", in_ready); end
  endtask

  task automatic test_identity();
    logic [2:0] vh;
    logic [7:0] y;
    logic [7:0] xs [4];
    int         ex [4];
    set_identity_lut();
    run_single(8'h25, vh, y);
    n_cmp++; if (vh !== 3'b100) begin n_fail++; $display("FAIL identity_latency: valid history %b, expected 100", vh); end
    n_cmp++; if ($signed(y) !== 8'sd37) begin n_fail++; $display("FAIL identity_data: got %0d, expected 37", $signed(y)); end
    xs = '{8'h7F, 8'h80, 8'hF8, 8'h00};
    ex = '{112, 0, 0, 0};
    for (int i = 0; i < 4; i++) begin
      run_single(xs[i], vh, y);
      n_cmp++; if (vh !== 3'b100) begin n_fail++; $display("FAIL boundary_latency x=%h: valid history %b, expected 100", xs[i], vh); end
      n_cmp++; if (int'($signed(y)) !== ex[i]) begin n_fail++; $display("FAIL boundary_data x=%h: got %0d, expected %0d", xs[i], $signed(y), ex[i]); end
    end
  endtask

  task automatic test_floor();
    logic [2:0] vh;
    logic [7:0] y;
    set_identity_lut();
    lut[3] = 8'sd127;
    lut[4] = -8'sd128;
    run_single(8'h3F, vh, y);
    n_cmp++; if (int'($signed(y)) !== -113) begin n_fail++; $display("FAIL floor_data: got %0d, expected -113", $signed(y)); end
    run_single(8'h30, vh, y);
    n_cmp++; if (int'($signed(y)) !== 127) begin n_fail++; $display("FAIL floor_frac0: got %0d, expected 127", $signed(y)); end
    set_identity_lut();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] stream [4];
    int got[$];
    int cyc[$];
    stream = '{8'h10, 8'h20, 8'h30, 8'h40};
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 4);
      in_data  = (c < 4) ? stream[c] : 8'($urandom);
      tick();
      if (out_valid) begin got.push_back(int'($signed(out_data))); cyc.push_back(c); end
    end
    n_cmp++; if (got.size() !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d outputs, expected 4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      n_cmp++; if (got[i] !== 16 * (i + 1)) begin n_fail++; $display("FAIL b2b_data[%0d]: got %0d, expected %0d", i, got[i], 16 * (i + 1)); end
      n_cmp++; if (cyc[i] !== 2 + i) begin n_fail++; $display("FAIL b2b_cycle[%0d]: got %0d, expected %0d", i, cyc[i], 2 + i); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] stream [4];
    int   got[$];
    int   cyc[$];
    int   idx, stall;
    bit   started, acc, pop;
    logic [7:0] pd;
    stream = '{8'h10, 8'h20, 8'h30, 8'h40};
    idx = 0; stall = 0; started = 0;
    for (int c = 0; c < 14; c++) begin
      if (!started && out_valid) begin started = 1; stall = 2; end
      out_ready = (stall == 0);
      in_valid  = (idx < 4);
      in_data   = (idx < 4) ? stream[idx] : 8'($urandom);
      #1;
      if (stall > 0) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready c=%0d: got %b, expected 0", c, in_ready); end
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'd16) begin n_fail++; $display("FAIL stall_hold c=%0d: got valid=%b data=%0d, expected 1/16", c, out_valid, out_data); end
        n_cmp++; if (lut_address !== stream[2][7:4]) begin n_fail++; $display("FAIL stall_lut_address c=%0d: got %h, expected %h", c, lut_address, stream[2][7:4]); end
      end
      acc = in_valid && in_ready;
      pop = out_valid && out_ready;
      pd  = out_data;
      tick();
      if (acc) idx++;
      if (pop) begin got.push_back(int'($signed(pd))); cyc.push_back(c); end
      if (stall > 0) stall--;
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    n_cmp++; if (started !== 1'b1 || idx !== 4) begin n_fail++; $display("FAIL bp_progress: got started=%b accepted=%0d, expected 1/4", started, idx); end
    n_cmp++; if (got.size() !== 4) begin n_fail++; $display("FAIL bp_count: got %0d outputs, expected 4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      n_cmp++; if (got[i] !== 16 * (i + 1)) begin n_fail++; $display("FAIL bp_data[%0d]: got %0d, expected %0d", i, got[i], 16 * (i + 1)); end
      n_cmp++; if (cyc[i] !== 5 + i) begin n_fail++; $display("FAIL bp_cycle[%0d]: got %0d, expected %0d", i, cyc[i], 5 + i); end
    end
  endtask

  task automatic test_reset_midstream();
    logic [2:0] vh;
    logic [7:0] y;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h10; tick();
    in_data   = 8'h20; tick();
    rst = 1'b0;
    in_data = 8'h30;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b, expected 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL mid_reset_data: got %h, expected 00", out_data); end
    n_cmp++; if (lut_address !== 4'h0) begin n_fail++; $display("FAIL mid_reset_addr: got %h, expected 0", lut_address); end
    rst = 1'b1;
    in_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_stale c=%0d: got valid=%b, expected 0", c, out_valid); end
    end
    run_single(8'h25, vh, y);
    n_cmp++; if (vh !== 3'b100) begin n_fail++; $display("FAIL post_reset_latency: valid history %b, expected 100", vh); end
    n_cmp++; if ($signed(y) !== 8'sd37) begin n_fail++; $display("FAIL post_reset_data: got %0d, expected 37", $signed(y)); end
  endtask

  task automatic test_random();
    int t;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 16; i++) lut[i] = 8'($urandom);
    lut[1] = 8'sd127;
    lut[2] = -8'sd128;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 20) begin tick(); t++; end
    n_cmp++; if (exp_q.size() != 0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL random_drain: %0d outstanding, valid=%b, expected 0/0", exp_q.size(), out_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    set_identity_lut();
    test_reset();
    test_identity();
    test_floor();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
